onehot4_monitor: RTL and testbench

- Sits directly downstream of the 2-to-4 line decoder and consumes its four active-high line outputs w, x, y, z.
- Checks that each sampled pattern is one-hot and re-encodes it to a registered 2-bit code.
- Keeps a saturating hit counter for each line and flags sticky errors for illegal patterns.
- Gives the bench and system a self-checking observation point on decoder traffic.

---
 rtl/onehot4_monitor.sv | 144 ++++++++++++++
 tb/tb_onehot4_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/onehot4_monitor.sv
// -----------------------------------------------------------------------------
// onehot4_monitor
//
// Purpose:
//   Observes the four active-high line outputs of a 2-to-4 decoder and checks
//   that every qualified sample is one-hot. A legal sample is re-encoded to a
//   registered 2-bit index and bumps a saturating per-line hit counter. An
//   illegal sample (no line or several lines set) raises a sticky error,
//   records the offending pattern and bumps a saturating error counter.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   qualifies w/x/y/z this cycle
//   w,x,y,z    in   decoder lines 0..3 (ab = 00,01,10,11)
//   clr        in   synchronous clear of counters and error state
//   rd_sel     in   selects which line counter drives rd_data
//   code_out   out  index of the last legal one-hot sample (registered)
//   code_valid out  one-cycle pulse when code_out was updated
//   err        out  sticky illegal-pattern flag
//   err_pat    out  {z,y,x,w} of the most recent illegal sample
//   err_cnt    out  saturating count of illegal samples
//   rd_data    out  hit count of line rd_sel (combinational read)
// -----------------------------------------------------------------------------
module onehot4_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             w,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    input  logic             clr,
    input  logic [1:0]       rd_sel,
    output logic [1:0]       code_out,
    output logic             code_valid,
    output logic             err,
    output logic [3:0]       err_pat,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] rd_data
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    // Returns {legal, index}; legal only for exactly one bit set.
    function automatic logic [2:0] onehot_decode(input logic [3:0] p);
        logic [2:0] r;
        case (p)
            4'b0001: r = 3'b100;
            4'b0010: r = 3'b101;
            4'b0100: r = 3'b110;
            4'b1000: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [1:0]       code_q,     code_d;
    logic             cv_q,       cv_d;
    logic             err_q,      err_d;
    logic [3:0]       pat_q,      pat_d;
    logic [CNT_W-1:0] ecnt_q,     ecnt_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    logic [3:0] pat_in;
    logic [2:0] dec;

    assign pat_in = {z, y, x, w};
    assign dec    = onehot_decode(pat_in);

    always_comb begin
        code_d = code_q;
        cv_d   = 1'b0;
        err_d  = err_q;
        pat_d  = pat_q;
        ecnt_d = ecnt_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        // clr wins over a same-cycle sample; the sample is simply dropped.
        if (clr) begin
            err_d  = 1'b0;
            pat_d  = 4'b0000;
            ecnt_d = '0;
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
            end
        end else if (in_valid) begin
            if (dec[2]) begin
                code_d          = dec[1:0];
                cv_d            = 1'b1;
                cnt_d[dec[1:0]] = sat_inc(cnt_q[dec[1:0]]);
            end else begin
                err_d  = 1'b1;
                pat_d  = pat_in;
                ecnt_d = sat_inc(ecnt_q);
            end
        end
    end

    // Sampling edge -> registered outputs (one cycle latency)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= 2'b00;
            cv_q   <= 1'b0;
            err_q  <= 1'b0;
            pat_q  <= 4'b0000;
            ecnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            code_q <= code_d;
            cv_q   <= cv_d;
            err_q  <= err_d;
            pat_q  <= pat_d;
            ecnt_q <= ecnt_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign code_out   = code_q;
    assign code_valid = cv_q;
    assign err        = err_q;
    assign err_pat    = pat_q;
    assign err_cnt    = ecnt_q;
    assign rd_data    = cnt_q[rd_sel];

endmodule

// File: tb/tb_onehot4_monitor.sv
`timescale 1ns/1ps
module tb_onehot4_monitor;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             w, x, y, z;
    logic             clr;
    logic [1:0]       rd_sel;
    logic [1:0]       code_out;
    logic             code_valid;
    logic             err;
    logic [3:0]       err_pat;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] rd_data;

    onehot4_monitor #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .w(w), .x(x), .y(y), .z(z), .clr(clr), .rd_sel(rd_sel),
        .code_out(code_out), .code_valid(code_valid), .err(err),
        .err_pat(err_pat), .err_cnt(err_cnt), .rd_data(rd_data)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, kept as plain integers.
    int       m_cnt [4];
    int       m_ecnt;
    bit       m_err;
    bit [3:0] m_pat;
    int       m_code;
    bit       m_cv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ecnt = 0; m_err = 0; m_pat = 0; m_code = 0; m_cv = 0;
    endtask

    task automatic model_step(input bit iv, input logic [3:0] p, input bit c);
        int ones;
        int idx;
        m_cv = 0;
        if (c) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_ecnt = 0; m_err = 0; m_pat = 0;
        end else if (iv) begin
            ones = 0; idx = 0;
            for (int i = 0; i < 4; i++) if (p[i] === 1'b1) begin ones++; idx = i; end
            if (ones == 1) begin
                m_code = idx;
                m_cv   = 1;
                if (m_cnt[idx] < MAXC) m_cnt[idx]++;
            end else begin
                m_err = 1;
                m_pat = p;
                if (m_ecnt < MAXC) m_ecnt++;
            end
        end
    endtask

    task automatic check_all();
        chk("code_out",   code_out,   m_code);
        chk("code_valid", code_valid, m_cv);
        chk("err",        err,        m_err);
        chk("err_pat",    err_pat,    m_pat);
        chk("err_cnt",    err_cnt,    m_ecnt);
        for (int r = 0; r < 4; r++) begin
            rd_sel = r[1:0];
            #1;
            chk($sformatf("rd_data[%0d]", r), rd_data, m_cnt[r]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then check after the rising edge.
    task automatic step(input bit iv, input logic [3:0] p, input bit c);
        @(negedge clk);
        in_valid = iv;
        {z, y, x, w} = p;
        clr = c;
        @(posedge clk);
        model_step(iv, p, c);
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] rp;
        rst_n = 1'b0; in_valid = 1'b0; {z, y, x, w} = 4'b0000; clr = 1'b0; rd_sel = 2'b00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Decoder sweep ab = 00..11
        for (int ab = 0; ab < 4; ab++) step(1'b1, 4'(1 << ab), 1'b0);

        // Illegal patterns
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0101, 1'b0);

        // Saturate line x
        for (int i = 0; i < 300; i++) step(1'b1, 4'b0010, 1'b0);

        // clr together with a legal z sample while err is set
        step(1'b1, 4'b1000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // in_valid low with garbage on the lines
        for (int i = 0; i < 5; i++) step(1'b0, (i % 2) ? 4'bxxxx : 4'b1111, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 6) rp = 4'(1 << $urandom_range(0, 3));
            else                          rp = 4'($urandom_range(0, 15));
            step(($urandom_range(0, 3) != 0), rp, ($urandom_range(0, 39) == 0));
        end

        // Asynchronous reset between edges
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0100, 1'b0);
        step(1'b1, 4'b0011, 1'b0);
        step(1'b1, 4'b0001, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        step(1'b1, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
